ofmap_readback_packer: RTL and testbench



---
 rtl/ofmap_readback_packer_if.sv | 13 +
 rtl/ofmap_readback_packer.sv | 194 +++++++++++++++++++
 tb/tb_ofmap_readback_packer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofmap_readback_packer_if.sv
// Packed-word stream from the ofmap readback packer to its consumer.
interface ofmap_readback_packer_if #(
  parameter int CH_W = 6
);
  logic            m_valid;
  logic            m_ready;
  logic [31:0]     m_data;
  logic [CH_W-1:0] m_ch;
  logic            m_last;

  modport master (output m_valid, m_data, m_ch, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_ch, m_last, output m_ready);
endinterface

// File: rtl/ofmap_readback_packer.sv
// Readback engine for the conv output buffer: walks n_ch x len entries, packs the low
// byte of each into little-endian 32-bit words and streams them out with backpressure.
module ofmap_readback_packer #(
  parameter int ADDR_W    = 22,
  parameter int TAG_W     = 5,
  parameter int TAG_SHIFT = 17,
  parameter int CH_SHIFT  = 10,
  parameter int CH_W      = 6,
  parameter int LEN_W     = 11,
  parameter int OUT_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [CH_W-1:0]         n_ch_i,
  input  logic [LEN_W-1:0]        len_i,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_en,
  input  logic [31:0]             mem_rddata,
  ofmap_readback_packer_if.master m
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int CHM_W = TAG_SHIFT - CH_SHIFT;
  localparam logic [ADDR_W-1:0] CH_MASK = ADDR_W'((64'd1 << CHM_W) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic            last;
    logic [CH_W-1:0] ch;
    logic [31:0]     data;
  } word_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q, cur_tag;
  logic [CH_W-1:0]   n_ch_q, cur_nch, ch_q, cur_ch;
  logic [LEN_W-1:0]  len_q, cur_len, j_q, cur_j;
  logic              issue, alloc, pop, push, last_j, last_ch;
  logic [ADDR_W-1:0] word_addr;

  // Read-phase tags travel with mem_en, data-phase tags line up with mem_rddata.
  logic [1:0]        rd_byte, dv_byte;
  logic              rd_flush, rd_last, dv, dv_flush, dv_last;
  logic [CH_W-1:0]   rd_ch, dv_ch;
  logic [31:0]       asm_q, asm_next;

  word_t             fifo_mem [OUT_DEPTH];
  word_t             head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, credit_q;

  logic              unused_rddata;
  assign unused_rddata = ^mem_rddata[31:8];

  assign pop  = m.m_valid && m.m_ready;
  assign push = dv && dv_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    cur_tag = tag_q;
    cur_nch = n_ch_q;
    cur_len = len_q;
    cur_ch  = ch_q;
    cur_j   = j_q;
    case (state_q)
      S_IDLE: begin
        // The first read goes out straight from the start inputs to save a cycle.
        cur_tag = tag_i;
        cur_nch = n_ch_i;
        cur_len = len_i;
        cur_ch  = '0;
        cur_j   = '0;
        if (start) begin
          if (n_ch_i == '0 || len_i == '0) begin
            state_d = S_DONE;
          end else begin
            issue   = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Opening a new word needs a guaranteed FIFO slot; a pop this cycle frees one.
        if (j_q[1:0] != 2'd0 || credit_q < CNT_W'(OUT_DEPTH) || pop) issue = 1'b1;
      end
      S_DRAIN: if (pop && m.m_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    last_j  = (cur_j == cur_len - LEN_W'(1));
    last_ch = (cur_ch == cur_nch - CH_W'(1));
    alloc   = issue && (cur_j[1:0] == 2'd0);
    if (issue && last_j && last_ch) state_d = S_DRAIN;
    word_addr = (ADDR_W'(cur_tag) << TAG_SHIFT)
              + ((ADDR_W'(cur_ch) & CH_MASK) << CH_SHIFT)
              + ADDR_W'(cur_j);
  end

  always_comb begin
    asm_next = (dv_byte == 2'd0) ? 32'd0 : asm_q;
    case (dv_byte)
      2'd0:    asm_next[7:0]   = mem_rddata[7:0];
      2'd1:    asm_next[15:8]  = mem_rddata[7:0];
      2'd2:    asm_next[23:16] = mem_rddata[7:0];
      default: asm_next[31:24] = mem_rddata[7:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q    <= '0;
      n_ch_q   <= '0;
      len_q    <= '0;
      ch_q     <= '0;
      j_q      <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      rd_byte  <= '0;
      rd_flush <= 1'b0;
      rd_last  <= 1'b0;
      rd_ch    <= '0;
      dv       <= 1'b0;
      dv_byte  <= '0;
      dv_flush <= 1'b0;
      dv_last  <= 1'b0;
      dv_ch    <= '0;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      credit_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        tag_q  <= tag_i;
        n_ch_q <= n_ch_i;
        len_q  <= len_i;
      end
      mem_en <= issue;
      if (issue) begin
        mem_addr <= word_addr << 2;
        rd_byte  <= cur_j[1:0];
        rd_flush <= (cur_j[1:0] == 2'd3) || last_j;
        rd_last  <= last_j && last_ch;
        rd_ch    <= cur_ch;
        if (last_j) begin
          j_q  <= '0;
          ch_q <= cur_ch + CH_W'(1);
        end else begin
          j_q  <= cur_j + LEN_W'(1);
          ch_q <= cur_ch;
        end
      end
      dv       <= mem_en;
      dv_byte  <= rd_byte;
      dv_flush <= rd_flush;
      dv_last  <= rd_last;
      dv_ch    <= rd_ch;
      if (dv) asm_q <= asm_next;
      if (push) wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      credit_q <= credit_q + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; the outputs are masked by m_valid so stale entries never leave.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{last: dv_last, ch: dv_ch, data: asm_next};
  end

  assign head      = fifo_mem[rd_ptr];
  assign m.m_valid = (fifo_cnt != '0);
  assign m.m_data  = m.m_valid ? head.data : 32'd0;
  assign m.m_ch    = m.m_valid ? head.ch   : '0;
  assign m.m_last  = m.m_valid && head.last;

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_ofmap_readback_packer.sv
// Directed bench for ofmap_readback_packer: BRAM model with 1-cycle latency, stream
// capture, and hand-computed expectations per scenario.
module tb_ofmap_readback_packer;
  localparam int ADDR_W    = 22;
  localparam int TAG_W     = 5;
  localparam int CH_W      = 6;
  localparam int LEN_W     = 11;
  localparam int OUT_DEPTH = 2;
  localparam logic [TAG_W-1:0] TAG_SA_DATA_BUF = 5'd2;

  typedef struct packed {
    logic            last;
    logic [CH_W-1:0] ch;
    logic [31:0]     data;
  } w_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [TAG_W-1:0]  tag_i = '0;
  logic [CH_W-1:0]   n_ch_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              busy, done, mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rddata;

  ofmap_readback_packer_if #(.CH_W(CH_W)) s_if ();

  ofmap_readback_packer dut (
    .clk(clk), .rst(rst), .start(start), .tag_i(tag_i), .n_ch_i(n_ch_i), .len_i(len_i),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_rddata(mem_rddata), .m(s_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int cfg_n, cfg_len, trk_ch, trk_j;
  int n_mem_en, cur_run, max_run, addr_err, stab_err, ovf_err, done_cnt;
  int start_cyc, done_cyc, last_xfer_cyc, first_en_cyc, fourth_en_cyc, first_valid_cyc;
  logic stall_prev = 1'b0;
  w_t   prev_w;
  w_t   got[$];
  w_t   exp_q[$];

  always @(posedge clk) cyc++;

  // Memory byte = (ch*7+j)&0xFF; upper bytes are junk the packer must ignore.
  always @(posedge clk) begin
    if (mem_en) begin
      int wa, ch, j;
      wa = int'(mem_addr >> 2);
      ch = (wa >> 10) & 127;
      j  = wa & 1023;
      mem_rddata <= {8'hA5, 8'h5A, 8'hC3, 8'((ch * 7 + j) & 255)};
    end
  end

  initial begin
    s_if.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       s_if.m_ready = 1'b1;
        1:       s_if.m_ready = ($urandom_range(0, 9) >= 3);
        default: s_if.m_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      cur_run    = 0;
    end else begin
      if (mem_en) begin
        logic [ADDR_W-1:0] ea;
        n_mem_en++;
        if (n_mem_en == 1) first_en_cyc = cyc;
        if (n_mem_en == 4) fourth_en_cyc = cyc;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        ea = ((ADDR_W'(TAG_SA_DATA_BUF) << 17) + (ADDR_W'(trk_ch & 127) << 10) + ADDR_W'(trk_j)) << 2;
        if (mem_addr !== ea) addr_err++;
        trk_j++;
        if (trk_j == cfg_len) begin trk_j = 0; trk_ch++; end
      end else begin
        cur_run = 0;
      end
      if (stall_prev && !(s_if.m_valid && s_if.m_data === prev_w.data &&
                          s_if.m_ch === prev_w.ch && s_if.m_last === prev_w.last))
        stab_err++;
      stall_prev = s_if.m_valid && !s_if.m_ready;
      prev_w     = '{last: s_if.m_last, ch: s_if.m_ch, data: s_if.m_data};
      if (s_if.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (s_if.m_valid && s_if.m_ready) begin
        got.push_back('{last: s_if.m_last, ch: s_if.m_ch, data: s_if.m_data});
        if (s_if.m_last) last_xfer_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (dut.fifo_cnt > OUT_DEPTH) ovf_err++;
    end
  end

  function automatic w_t mk(input logic last, input int ch, input logic [31:0] data);
    return '{last: last, ch: CH_W'(ch), data: data};
  endfunction

  function automatic w_t got_at(input int i);
    if (i >= 0 && i < got.size()) return got[i];
    return '0;
  endfunction

  function automatic int first_mismatch();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    if (got.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic build_exp(input int n, input int len);
    exp_q.delete();
    for (int ch = 0; ch < n; ch++) begin
      int nw;
      nw = (len + 3) / 4;
      for (int w = 0; w < nw; w++) begin
        logic [31:0] d;
        d = '0;
        for (int b = 0; b < 4; b++)
          if (4 * w + b < len) d[8*b +: 8] = 8'((ch * 7 + 4 * w + b) & 255);
        exp_q.push_back(mk(ch == n - 1 && w == nw - 1, ch, d));
      end
    end
  endtask

  task automatic launch(input int n, input int len);
    cfg_n = n; cfg_len = len; trk_ch = 0; trk_j = 0;
    got.delete();
    n_mem_en = 0; max_run = 0; cur_run = 0; addr_err = 0; stab_err = 0; ovf_err = 0;
    done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1;
    first_en_cyc = -1; fourth_en_cyc = -1; first_valid_cyc = -1;
    build_exp(n, len);
    @(posedge clk); #1;
    tag_i = TAG_SA_DATA_BUF; n_ch_i = CH_W'(n); len_i = LEN_W'(len);
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin @(posedge clk); k++; end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done pulses: got %0d expected 1 within %0d cycles", name, done_cnt, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy, done, mem_en, s_if.m_valid, s_if.m_last, mem_addr, s_if.m_data, s_if.m_ch} !== '0) begin
      errors++;
      $display("FAIL reset outputs: busy=%b done=%b en=%b valid=%b addr=%h data=%h", busy, done,
               mem_en, s_if.m_valid, mem_addr, s_if.m_data);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, mem_en, s_if.m_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle after reset: busy=%b en=%b valid=%b expected 000", busy, mem_en, s_if.m_valid);
    end
  endtask

  task automatic test_basic();
    int bad, nlast;
    launch(6, 196);
    wait_done("basic", 3000);
    checks++;
    if (got.size() != 294) begin errors++; $display("FAIL basic words: got %0d expected 294", got.size()); end
    checks++;
    if (got_at(0) !== mk(0, 0, 32'h03020100)) begin
      errors++; $display("FAIL basic word0: got %h expected %h", got_at(0), mk(0, 0, 32'h03020100));
    end
    checks++;
    if (got_at(49) !== mk(0, 1, 32'h0A090807)) begin
      errors++; $display("FAIL basic ch1 word0: got %h expected %h", got_at(49), mk(0, 1, 32'h0A090807));
    end
    checks++;
    if (got_at(293) !== mk(1, 5, 32'hE6E5E4E3)) begin
      errors++; $display("FAIL basic last word: got %h expected %h", got_at(293), mk(1, 5, 32'hE6E5E4E3));
    end
    nlast = 0;
    foreach (got[i]) if (got[i].last) nlast++;
    checks++;
    if (nlast != 1) begin errors++; $display("FAIL basic m_last count: got %0d expected 1", nlast); end
    bad = first_mismatch();
    checks++;
    if (bad != -1) begin
      errors++; $display("FAIL basic stream at %0d: got %h expected %h", bad, got_at(bad), exp_q[bad]);
    end
    checks++;
    if (n_mem_en != 1176 || addr_err != 0) begin
      errors++; $display("FAIL basic reads: got %0d (addr errs %0d) expected 1176 (0)", n_mem_en, addr_err);
    end
    checks++;
    if (done_cyc != last_xfer_cyc + 1) begin
      errors++; $display("FAIL basic done timing: got cycle %0d expected %0d", done_cyc, last_xfer_cyc + 1);
    end
    checks++;
    if (first_en_cyc != start_cyc + 1) begin
      errors++; $display("FAIL basic first mem_en: got cycle %0d expected %0d", first_en_cyc, start_cyc + 1);
    end
    checks++;
    if (first_valid_cyc < 0 || first_valid_cyc > fourth_en_cyc + 3) begin
      errors++; $display("FAIL basic first valid: got cycle %0d expected <= %0d", first_valid_cyc, fourth_en_cyc + 3);
    end
  endtask

  task automatic test_partial();
    launch(2, 5);
    wait_done("partial", 200);
    checks++;
    if (got.size() != 4) begin errors++; $display("FAIL partial words: got %0d expected 4", got.size()); end
    checks++;
    if (got_at(1) !== mk(0, 0, 32'h00000004)) begin
      errors++; $display("FAIL partial word1: got %h expected %h", got_at(1), mk(0, 0, 32'h00000004));
    end
    checks++;
    if (got_at(2) !== mk(0, 1, 32'h0A090807)) begin
      errors++; $display("FAIL partial word2: got %h expected %h", got_at(2), mk(0, 1, 32'h0A090807));
    end
    checks++;
    if (got_at(3) !== mk(1, 1, 32'h0000000B)) begin
      errors++; $display("FAIL partial word3: got %h expected %h", got_at(3), mk(1, 1, 32'h0000000B));
    end
    checks++;
    if (n_mem_en != 10 || addr_err != 0) begin
      errors++; $display("FAIL partial reads: got %0d (addr errs %0d) expected 10 (0)", n_mem_en, addr_err);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    rdy_mode = 1;
    launch(6, 196);
    repeat (40) @(posedge clk);
    rdy_mode = 2;
    repeat (50) @(posedge clk);
    rdy_mode = 1;
    wait_done("backpressure", 8000);
    rdy_mode = 0;
    bad = first_mismatch();
    checks++;
    if (bad != -1) begin
      errors++; $display("FAIL backpressure stream at %0d: got %h expected %h", bad, got_at(bad), exp_q[bad]);
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL backpressure stability: got %0d changes expected 0", stab_err); end
    checks++;
    if (ovf_err != 0) begin errors++; $display("FAIL backpressure fifo overflow: got %0d expected 0", ovf_err); end
    checks++;
    if (n_mem_en != 1176 || addr_err != 0) begin
      errors++; $display("FAIL backpressure reads: got %0d (addr errs %0d) expected 1176 (0)", n_mem_en, addr_err);
    end
  endtask

  task automatic test_degenerate();
    launch(3, 0);
    wait_done("degenerate len0", 20);
    checks++;
    if (done_cyc != start_cyc + 1 || n_mem_en != 0 || got.size() != 0) begin
      errors++; $display("FAIL degenerate len0: done cyc %0d (exp %0d) reads %0d words %0d expected 0/0",
                         done_cyc, start_cyc + 1, n_mem_en, got.size());
    end
    launch(0, 5);
    wait_done("degenerate nch0", 20);
    checks++;
    if (done_cyc != start_cyc + 1 || n_mem_en != 0 || got.size() != 0) begin
      errors++; $display("FAIL degenerate nch0: done cyc %0d (exp %0d) reads %0d words %0d expected 0/0",
                         done_cyc, start_cyc + 1, n_mem_en, got.size());
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    launch(2, 20);
    repeat (8) @(posedge clk); #1;
    n_ch_i = 6'd5; len_i = 11'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("start ignored", 300);
    bad = first_mismatch();
    checks++;
    if (bad != -1 || got.size() != 10) begin
      errors++; $display("FAIL start ignored stream at %0d: got %0d words expected 10", bad, got.size());
    end
    checks++;
    if (n_mem_en != 40 || addr_err != 0) begin
      errors++; $display("FAIL start ignored reads: got %0d (addr errs %0d) expected 40 (0)", n_mem_en, addr_err);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    launch(6, 196);
    k = 0;
    while (got.size() < 50 && k < 2000) begin @(posedge clk); k++; end
    checks++;
    if (got.size() < 50) begin errors++; $display("FAIL reset mid progress: got %0d words expected 50", got.size()); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, mem_en, s_if.m_valid, s_if.m_last, mem_addr, s_if.m_data, s_if.m_ch} !== '0) begin
      errors++;
      $display("FAIL reset mid outputs: busy=%b done=%b en=%b valid=%b addr=%h data=%h", busy, done,
               mem_en, s_if.m_valid, mem_addr, s_if.m_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset mid abort: done pulses %0d busy %b expected 0 0", done_cnt, busy);
    end
    launch(1, 4);
    wait_done("after reset", 100);
    checks++;
    if (got.size() != 1 || got_at(0) !== mk(1, 0, 32'h03020100)) begin
      errors++; $display("FAIL after reset word: got %0d words %h expected 1 %h", got.size(), got_at(0),
                         mk(1, 0, 32'h03020100));
    end
  endtask

  task automatic test_throughput();
    int bad;
    launch(1, 1024);
    wait_done("throughput", 1100);
    checks++;
    if (max_run != 1024 || n_mem_en != 1024) begin
      errors++; $display("FAIL throughput reads: longest run %0d total %0d expected 1024 1024", max_run, n_mem_en);
    end
    checks++;
    if (got.size() != 256 || got_at(255) !== mk(1, 0, 32'hFFFEFDFC)) begin
      errors++; $display("FAIL throughput words: got %0d last %h expected 256 %h", got.size(), got_at(255),
                         mk(1, 0, 32'hFFFEFDFC));
    end
    checks++;
    if (done_cyc < 0 || done_cyc - start_cyc > 1030) begin
      errors++; $display("FAIL throughput latency: got %0d cycles expected <= 1030", done_cyc - start_cyc);
    end
    bad = first_mismatch();
    checks++;
    if (bad != -1) begin
      errors++; $display("FAIL throughput stream at %0d: got %h expected %h", bad, got_at(bad), exp_q[bad]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_degenerate();
    test_start_ignored();
    test_reset_mid();
    test_throughput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
